// File: rtl/alu_pkg.sv
// Shared opcode constants and opcode field helpers for the one-bit ALU slice.
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_ORN  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_ANDN = 3'b101;
  localparam logic [2:0] OP_NOTA = 3'b110;
  localparam logic [2:0] OP_NOTB = 3'b111;

  // Bit positions: OP_INVB = c[0], OP_SEL = c[2:1].
  localparam int OP_INVB    = 0;
  localparam int OP_SEL_MSB = 2;
  localparam int OP_SEL_LSB = 1;

  typedef enum logic [1:0] {
    SEL_ARITH = 2'b00,
    SEL_OR    = 2'b01,
    SEL_AND   = 2'b10,
    SEL_NOT   = 2'b11
  } sel_e;

  function automatic logic op_invb(input logic [2:0] op);
    return op[OP_INVB];
  endfunction

  function automatic sel_e op_sel(input logic [2:0] op);
    return sel_e'(op[OP_SEL_MSB:OP_SEL_LSB]);
  endfunction

endpackage

// File: rtl/alu_bitslice_full_adder.sv
// One-bit full adder used as the arithmetic core of each ALU slice.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/alu_bitslice.sv
// One-bit ALU slice: combinational result/carry plus registered copies for pipelined use.
import alu_pkg::*;

module alu_bitslice (
  input  logic       clk,
  input  logic       rst,
  input  logic       a,
  input  logic       b,
  input  logic [2:0] c,
  input  logic       c_in,
  output logic       f_out,
  output logic       c_out,
  output logic       f_reg,
  output logic       c_reg
);

  logic w_bx;
  logic w_sum;
  logic w_carry;
  logic w_f;
  logic r_f;
  logic r_c;

  assign w_bx = op_invb(c) ? ~b : b;

  // The carry chain is always the adder carry, whatever the opcode selects for f.
  full_adder u_fa (
    .a  (a),
    .b  (w_bx),
    .ci (c_in),
    .s  (w_sum),
    .co (w_carry)
  );

  // In the NOT group the inverter bit picks ~b (already in w_bx) over ~a.
  always_comb begin
    w_f = 1'b0;
    case (op_sel(c))
      SEL_ARITH: w_f = w_sum;
      SEL_OR:    w_f = a | w_bx;
      SEL_AND:   w_f = a & w_bx;
      SEL_NOT:   w_f = op_invb(c) ? w_bx : ~a;
      default:   w_f = 1'b0;
    endcase
  end

  assign f_out = w_f;
  assign c_out = w_carry;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_f <= 1'b0;
      r_c <= 1'b0;
    end else begin
      r_f <= w_f;
      r_c <= w_carry;
    end
  end

  assign f_reg = r_f;
  assign c_reg = r_c;

`ifndef SYNTHESIS
  // Independent 64-entry truth table, indexed by {c, c_in, b, a}.
  function automatic logic [1:0] ref_fc(input logic [5:0] idx);
    logic [2:0] op;
    logic       ra, rb, rci, rbx, rf;
    logic [1:0] tot;
    {op, rci, rb, ra} = idx;
    rbx = op[0] ? ~rb : rb;
    tot = {1'b0, ra} + {1'b0, rbx} + {1'b0, rci};
    case (op)
      OP_ADD:  rf = tot[0];
      OP_SUB:  rf = tot[0];
      OP_OR:   rf = ra | rb;
      OP_ORN:  rf = ra | ~rb;
      OP_AND:  rf = ra & rb;
      OP_ANDN: rf = ra & ~rb;
      OP_NOTA: rf = ~ra;
      OP_NOTB: rf = ~rb;
      default: rf = 1'b0;
    endcase
    return {rf, tot[1]};
  endfunction

  always_ff @(posedge clk) begin
    a_truth_table: assert ({f_out, c_out} == ref_fc({c, c_in, b, a}));
  end
`endif

endmodule

// File: tb/tb_alu_bitslice.sv
// Self-checking bench for alu_bitslice: exhaustive sweep, random vectors, reset and ripple chain.
module tb_alu_bitslice;

  logic       clk;
  logic       rst;
  logic       a;
  logic       b;
  logic [2:0] c;
  logic       c_in;
  logic       f_out;
  logic       c_out;
  logic       f_reg;
  logic       c_reg;

  int errorCount = 0;
  int checkCount = 0;

  alu_bitslice dut (
    .clk   (clk),
    .rst   (rst),
    .a     (a),
    .b     (b),
    .c     (c),
    .c_in  (c_in),
    .f_out (f_out),
    .c_out (c_out),
    .f_reg (f_reg),
    .c_reg (c_reg)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Behavioural model: carry from integer addition, f from the opcode's boolean rule.
  function automatic logic [1:0] modelOut(input int op, input int ia, input int ib, input int icin);
    int bv, total, fv;
    bv    = (op % 2 == 1) ? 1 - ib : ib;
    total = ia + bv + icin;
    case (op)
      0, 1:    fv = total % 2;
      2:       fv = (ia == 1 || ib == 1) ? 1 : 0;
      3:       fv = (ia == 1 || ib == 0) ? 1 : 0;
      4:       fv = (ia == 1 && ib == 1) ? 1 : 0;
      5:       fv = (ia == 1 && ib == 0) ? 1 : 0;
      6:       fv = 1 - ia;
      default: fv = 1 - ib;
    endcase
    return {fv[0], (total >= 2)};
  endfunction

  task automatic checkOutput(input string tag, input logic observed, input logic expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %b expected %b", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic ia, input logic ib, input logic icin);
    @(negedge clk);
    c    = op;
    a    = ia;
    b    = ib;
    c_in = icin;
    #1;
  endtask

  task automatic checkComb(input string tag, input int op, input int ia, input int ib, input int icin);
    logic [1:0] exp;
    exp = modelOut(op, ia, ib, icin);
    checkOutput({tag, "_f"}, f_out, exp[1]);
    checkOutput({tag, "_c"}, c_out, exp[0]);
  endtask

  // Runs a 4-slice ripple through the single DUT, feeding each carry-out forward.
  task automatic runChain(input string tag, input logic [2:0] op, input int aw, input int bw, input int cin0);
    logic carry;
    int   res, expWide, bEff;
    carry = cin0[0];
    res   = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(op, aw[i], bw[i], carry);
      res   = res | (int'(f_out) << i);
      carry = c_out;
    end
    bEff    = (op == 3'b001) ? (~bw & 15) : bw;
    expWide = aw + bEff + cin0;
    checkOutput({tag, "_r0"}, res[0] === 1'b1, expWide[0] == 1);
    checkOutput({tag, "_r1"}, res[1] === 1'b1, expWide[1] == 1);
    checkOutput({tag, "_r2"}, res[2] === 1'b1, expWide[2] == 1);
    checkOutput({tag, "_r3"}, res[3] === 1'b1, expWide[3] == 1);
    checkOutput({tag, "_cout"}, carry, expWide[4] == 1);
  endtask

  typedef struct {
    logic [2:0] op;
    logic       ia;
    logic       ib;
    logic       icin;
  } spot_t;

  spot_t spots[$];

  initial begin
    logic       prevF, prevC;
    logic [1:0] exp;
    logic [5:0] v;

    rst  = 1'b1;
    a    = 1'b0;
    b    = 1'b0;
    c    = 3'b000;
    c_in = 1'b0;

    // Reset held two cycles with ADD 1,1,1 applied.
    applyStimulus(3'b000, 1'b1, 1'b1, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("rst_freg", f_reg, 1'b0);
    checkOutput("rst_creg", c_reg, 1'b0);
    checkOutput("rst_fout", f_out, 1'b1);
    checkOutput("rst_cout", c_out, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rel_freg", f_reg, 1'b1);
    checkOutput("rel_creg", c_reg, 1'b1);
    prevF = 1'b1;
    prevC = 1'b1;

    // Exhaustive sweep of {c, c_in, b, a}, one vector per 40 ns.
    for (int i = 0; i < 64; i++) begin
      v = 6'(i);
      applyStimulus(v[5:3], v[0], v[1], v[2]);
      exp = modelOut(int'(v[5:3]), int'(v[0]), int'(v[1]), int'(v[2]));
      checkOutput($sformatf("sweep%0d_f", i), f_out, exp[1]);
      checkOutput($sformatf("sweep%0d_c", i), c_out, exp[0]);
      checkOutput($sformatf("lag%0d_f", i), f_reg, prevF);
      checkOutput($sformatf("lag%0d_c", i), c_reg, prevC);
      if (i == 32) rst = 1'b1;
      @(posedge clk);
      #1;
      if (i == 32) begin
        checkOutput("midrst_freg", f_reg, 1'b0);
        checkOutput("midrst_creg", c_reg, 1'b0);
        checkOutput("midrst_fout", f_out, exp[1]);
        checkOutput("midrst_cout", c_out, exp[0]);
        rst   = 1'b0;
        prevF = 1'b0;
        prevC = 1'b0;
      end else begin
        checkOutput($sformatf("reg%0d_f", i), f_reg, exp[1]);
        checkOutput($sformatf("reg%0d_c", i), c_reg, exp[0]);
        prevF = exp[1];
        prevC = exp[0];
      end
      @(negedge clk);
    end

    // Named corner cases from each opcode group.
    spots.push_back('{3'b000, 1'b1, 1'b1, 1'b0});
    spots.push_back('{3'b000, 1'b1, 1'b1, 1'b1});
    spots.push_back('{3'b001, 1'b1, 1'b0, 1'b0});
    spots.push_back('{3'b001, 1'b0, 1'b1, 1'b1});
    spots.push_back('{3'b001, 1'b0, 1'b0, 1'b1});
    spots.push_back('{3'b010, 1'b0, 1'b0, 1'b1});
    spots.push_back('{3'b011, 1'b0, 1'b0, 1'b0});
    spots.push_back('{3'b100, 1'b0, 1'b1, 1'b1});
    spots.push_back('{3'b101, 1'b1, 1'b0, 1'b1});
    spots.push_back('{3'b110, 1'b0, 1'b1, 1'b0});
    spots.push_back('{3'b110, 1'b0, 1'b1, 1'b1});
    spots.push_back('{3'b111, 1'b1, 1'b0, 1'b0});
    spots.push_back('{3'b111, 1'b1, 1'b1, 1'b1});
    foreach (spots[k]) begin
      applyStimulus(spots[k].op, spots[k].ia, spots[k].ib, spots[k].icin);
      checkComb($sformatf("spot%0d", k), int'(spots[k].op), int'(spots[k].ia),
                int'(spots[k].ib), int'(spots[k].icin));
    end

    // Random single-slice vectors.
    for (int n = 0; n < 40; n++) begin
      int rop, ra, rb, rc;
      rop = int'($urandom_range(7, 0));
      ra  = int'($urandom_range(1, 0));
      rb  = int'($urandom_range(1, 0));
      rc  = int'($urandom_range(1, 0));
      applyStimulus(rop[2:0], ra[0], rb[0], rc[0]);
      checkComb($sformatf("rand%0d", n), rop, ra, rb, rc);
    end

    // Ripple chain: the two fixed cases plus random operands.
    runChain("chain_sub", 3'b001, 5, 3, 1);
    runChain("chain_add", 3'b000, 5, 3, 0);
    for (int n = 0; n < 8; n++) begin
      int aw, bw, isSub;
      aw    = int'($urandom_range(15, 0));
      bw    = int'($urandom_range(15, 0));
      isSub = int'($urandom_range(1, 0));
      runChain($sformatf("chain_rand%0d", n), (isSub == 1) ? 3'b001 : 3'b000, aw, bw, isSub);
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
